arbitro_memoria_corte: RTL and testbench

// Sequences and shares the 512x12 coordinate memory between three requesters:
//   the point recorder (write), the cut playback path (read) and the clear command.

---
 rtl/arbitro_memoria_corte_pkg.sv | 23 ++
 rtl/arbitro_memoria_corte_if.sv | 41 ++++
 rtl/arbitro_memoria_corte_rr2.sv | 35 +++
 rtl/arbitro_memoria_corte.sv | 147 ++++++++++++++
 tb/tb_arbitro_memoria_corte.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/arbitro_memoria_corte_pkg.sv
// Shared constants and FSM encoding for the coordinate-memory arbiter.
// Points are packed {x, y}, one BITS_EJE-bit field per axis.
package arbitro_memoria_corte_pkg;

  localparam int BITS_EJE         = 6;
  localparam int BITS_COORDENADA  = 2 * BITS_EJE;
  localparam int DIRECCIONAMIENTO = 9;
  localparam int CAPACIDAD        = 2 ** DIRECCIONAMIENTO;
  localparam int BITS_PUNTERO     = DIRECCIONAMIENTO + 1;

  localparam logic [BITS_PUNTERO-1:0] PUNTERO_LLENO = BITS_PUNTERO'(CAPACIDAD);

  typedef enum logic [2:0] {
    REPOSO,
    ESCRIBIR,
    LLENO_ERR,
    LEER,
    ESPERA_LECT,
    FIN_LECT,
    BORRAR
  } estado_t;

endpackage

// File: rtl/arbitro_memoria_corte_if.sv
// Requester and memory-port signals of the arbiter.
// The slave modport is the arbiter's view; master is the controller/memory side.
interface arbitro_memoria_corte_if;
  import arbitro_memoria_corte_pkg::*;

  logic                         escribir_req;
  logic [BITS_COORDENADA-1:0]   escribir_dato;
  logic                         escribir_ack;
  logic                         escribir_error;
  logic                         leer_req;
  logic                         leer_ack;
  logic                         leer_fin;
  logic [BITS_COORDENADA-1:0]   leer_dato;
  logic                         leer_valido;
  logic                         rebobinar;
  logic                         borrar_req;
  logic                         borrar_ack;
  logic [DIRECCIONAMIENTO-1:0]  mem_direccion;
  logic [BITS_COORDENADA-1:0]   mem_dato_escribir;
  logic                         mem_leer_escribir;
  logic                         mem_reset;
  logic [BITS_COORDENADA-1:0]   mem_dato_leer;
  logic [BITS_PUNTERO-1:0]      num_puntos;
  logic                         vacio;
  logic                         lleno;

  modport slave (
    input  escribir_req, escribir_dato, leer_req, rebobinar, borrar_req, mem_dato_leer,
    output escribir_ack, escribir_error, leer_ack, leer_fin, leer_dato, leer_valido,
           borrar_ack, mem_direccion, mem_dato_escribir, mem_leer_escribir, mem_reset,
           num_puntos, vacio, lleno
  );

  modport master (
    output escribir_req, escribir_dato, leer_req, rebobinar, borrar_req, mem_dato_leer,
    input  escribir_ack, escribir_error, leer_ack, leer_fin, leer_dato, leer_valido,
           borrar_ack, mem_direccion, mem_dato_escribir, mem_leer_escribir, mem_reset,
           num_puntos, vacio, lleno
  );

endinterface

// File: rtl/arbitro_memoria_corte_rr2.sv
// Two-requester round-robin: on a tie the type served last loses.
// Requester A (write) wins the first tie after reset.
module arbitro_memoria_corte_rr2 (
  input  logic clock_i,
  input  logic reset_ni,
  input  logic en_i,
  input  logic req_a_i,
  input  logic req_b_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

  logic ultimo_b_q;
  logic ultimo_b_d;

  always_comb begin
    gnt_a_o    = en_i && req_a_i && (!req_b_i || ultimo_b_q);
    gnt_b_o    = en_i && req_b_i && (!req_a_i || !ultimo_b_q);
    ultimo_b_d = ultimo_b_q;
    if (gnt_a_o) begin
      ultimo_b_d = 1'b0;
    end else if (gnt_b_o) begin
      ultimo_b_d = 1'b1;
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ultimo_b_q <= 1'b1;
    end else begin
      ultimo_b_q <= ultimo_b_d;
    end
  end

endmodule

// File: rtl/arbitro_memoria_corte.sv
// Shares the 512x12 coordinate memory between the point recorder, cut playback and clear.
// Owns both pointers and is the only driver of the memory port; all outputs are registered.
module arbitro_memoria_corte
  import arbitro_memoria_corte_pkg::*;
(
  input  logic                   clock_i,
  input  logic                   reset_ni,
  arbitro_memoria_corte_if.slave bus_io
);

  estado_t                      estado_q;
  logic [BITS_PUNTERO-1:0]      wr_ptr_q;
  logic [BITS_PUNTERO-1:0]      rd_ptr_q;
  logic [BITS_PUNTERO-1:0]      rd_efectivo;
  logic                         escribir_ack_q;
  logic                         escribir_error_q;
  logic                         leer_ack_q;
  logic                         leer_fin_q;
  logic                         leer_valido_q;
  logic                         borrar_ack_q;
  logic [BITS_COORDENADA-1:0]   leer_dato_q;
  logic [DIRECCIONAMIENTO-1:0]  mem_dir_q;
  logic [BITS_COORDENADA-1:0]   mem_dato_q;
  logic                         mem_rw_q;
  logic                         mem_reset_q;
  logic                         lleno;
  logic                         gnt_escribir;
  logic                         gnt_leer;

  assign lleno = (wr_ptr_q == PUNTERO_LLENO);

  // A rewind that coincides with a read grant is applied before the grant looks at rd_ptr.
  assign rd_efectivo = bus_io.rebobinar ? '0 : rd_ptr_q;

  arbitro_memoria_corte_rr2 u_rr2 (
    .clock_i  (clock_i),
    .reset_ni (reset_ni),
    .en_i     ((estado_q == REPOSO) && !bus_io.borrar_req),
    .req_a_i  (bus_io.escribir_req),
    .req_b_i  (bus_io.leer_req),
    .gnt_a_o  (gnt_escribir),
    .gnt_b_o  (gnt_leer)
  );

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      estado_q         <= REPOSO;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      leer_dato_q      <= '0;
      escribir_ack_q   <= 1'b0;
      escribir_error_q <= 1'b0;
      leer_ack_q       <= 1'b0;
      leer_fin_q       <= 1'b0;
      leer_valido_q    <= 1'b0;
      borrar_ack_q     <= 1'b0;
      mem_dir_q        <= '0;
      mem_dato_q       <= '0;
      mem_rw_q         <= 1'b0;
      mem_reset_q      <= 1'b0;
    end else begin
      escribir_ack_q   <= 1'b0;
      escribir_error_q <= 1'b0;
      leer_ack_q       <= 1'b0;
      leer_fin_q       <= 1'b0;
      leer_valido_q    <= 1'b0;
      borrar_ack_q     <= 1'b0;
      mem_dir_q        <= '0;
      mem_dato_q       <= '0;
      mem_rw_q         <= 1'b0;
      mem_reset_q      <= 1'b0;
      unique case (estado_q)
        REPOSO: begin
          if (bus_io.rebobinar) begin
            rd_ptr_q <= '0;
          end
          if (bus_io.borrar_req) begin
            estado_q     <= BORRAR;
            borrar_ack_q <= 1'b1;
            mem_reset_q  <= 1'b1;
          end else if (gnt_escribir) begin
            if (lleno) begin
              estado_q         <= LLENO_ERR;
              escribir_error_q <= 1'b1;
            end else begin
              estado_q       <= ESCRIBIR;
              escribir_ack_q <= 1'b1;
              mem_rw_q       <= 1'b1;
              mem_dir_q      <= wr_ptr_q[DIRECCIONAMIENTO-1:0];
              mem_dato_q     <= bus_io.escribir_dato;
            end
          end else if (gnt_leer) begin
            leer_ack_q <= 1'b1;
            if (rd_efectivo == wr_ptr_q) begin
              estado_q   <= FIN_LECT;
              leer_fin_q <= 1'b1;
            end else begin
              estado_q  <= LEER;
              mem_dir_q <= rd_efectivo[DIRECCIONAMIENTO-1:0];
            end
          end
        end
        ESCRIBIR: begin
          wr_ptr_q <= wr_ptr_q + BITS_PUNTERO'(1);
          estado_q <= REPOSO;
        end
        LEER: begin
          estado_q <= ESPERA_LECT;
        end
        // The memory answers one cycle after the address, so the word is captured here.
        ESPERA_LECT: begin
          leer_dato_q   <= bus_io.mem_dato_leer;
          leer_valido_q <= 1'b1;
          rd_ptr_q      <= rd_ptr_q + BITS_PUNTERO'(1);
          estado_q      <= REPOSO;
        end
        BORRAR: begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          estado_q <= REPOSO;
        end
        LLENO_ERR, FIN_LECT: begin
          estado_q <= REPOSO;
        end
        default: begin
          estado_q <= REPOSO;
        end
      endcase
    end
  end

  assign bus_io.escribir_ack      = escribir_ack_q;
  assign bus_io.escribir_error    = escribir_error_q;
  assign bus_io.leer_ack          = leer_ack_q;
  assign bus_io.leer_fin          = leer_fin_q;
  assign bus_io.leer_dato         = leer_dato_q;
  assign bus_io.leer_valido       = leer_valido_q;
  assign bus_io.borrar_ack        = borrar_ack_q;
  assign bus_io.mem_direccion     = mem_dir_q;
  assign bus_io.mem_dato_escribir = mem_dato_q;
  assign bus_io.mem_leer_escribir = mem_rw_q;
  assign bus_io.mem_reset         = mem_reset_q;
  assign bus_io.num_puntos        = wr_ptr_q;
  assign bus_io.vacio             = (wr_ptr_q == '0);
  assign bus_io.lleno             = lleno;

endmodule

// File: tb/tb_arbitro_memoria_corte.sv
// Scoreboard bench: a point-list model predicts the grant sequence and data,
// and a negedge monitor compares every strobe the arbiter produces.
module tb_arbitro_memoria_corte;
  import arbitro_memoria_corte_pkg::*;

  typedef enum int {EV_WRITE, EV_ERROR, EV_READ, EV_FIN, EV_BORRAR} evKind_t;
  typedef struct {
    evKind_t kind;
    int      addr;
    int      data;
  } ev_t;

  logic clock = 1'b0;
  logic resetN = 1'b0;
  always #5 clock = ~clock;

  arbitro_memoria_corte_if bus ();

  arbitro_memoria_corte dut (
    .clock_i  (clock),
    .reset_ni (resetN),
    .bus_io   (bus)
  );

  int assertions = 0;
  int failures = 0;
  int ciclo = 0;
  ev_t expEventos[$];
  int expDatos[$];
  int ackCiclos[$];
  int datosFijos[$];

  int mWr = 0;
  int mRd = 0;
  bit mLastWrite = 1'b0;
  int mPuntos[CAPACIDAD];

  logic [BITS_COORDENADA-1:0] memoria[CAPACIDAD];

  evKind_t obs;
  ev_t esperado;

  // Stand-in for memoria4K: synchronous write/clear, registered read.
  always @(posedge clock) begin
    if (bus.mem_reset) begin
      for (int i = 0; i < CAPACIDAD; i++) memoria[i] <= '0;
    end else if (bus.mem_leer_escribir) begin
      memoria[bus.mem_direccion] <= bus.mem_dato_escribir;
    end
    bus.mem_dato_leer <= memoria[bus.mem_direccion];
  end

  always @(posedge clock) ciclo <= ciclo + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, ciclo);
    end
  endtask

  function automatic logic [63:0] salidas();
    return {13'd0, bus.escribir_ack, bus.escribir_error, bus.leer_ack, bus.leer_fin,
            bus.leer_dato, bus.leer_valido, bus.borrar_ack, bus.mem_direccion,
            bus.mem_dato_escribir, bus.mem_leer_escribir, bus.mem_reset, bus.num_puntos};
  endfunction

  // Reference: serve the pending set one grant at a time using the arbitration rules.
  task automatic predict(input int nW, input int nR, input bit b, input bit rew, input int datos[$]);
    int w = 0;
    int r = 0;
    bit bPend = b;
    bit doWrite;
    if (rew) mRd = 0;
    while (bPend || w < nW || r < nR) begin
      if (bPend) begin
        expEventos.push_back('{EV_BORRAR, 0, 0});
        mWr = 0;
        mRd = 0;
        bPend = 1'b0;
      end else begin
        doWrite = (w < nW) && (!(r < nR) || !mLastWrite);
        if (doWrite) begin
          if (mWr == CAPACIDAD) begin
            expEventos.push_back('{EV_ERROR, 0, 0});
          end else begin
            expEventos.push_back('{EV_WRITE, mWr, datos[w]});
            mPuntos[mWr] = datos[w];
            mWr++;
          end
          w++;
          mLastWrite = 1'b1;
        end else begin
          if (mRd == mWr) begin
            expEventos.push_back('{EV_FIN, 0, 0});
          end else begin
            expEventos.push_back('{EV_READ, mRd, 0});
            expDatos.push_back(mPuntos[mRd]);
            mRd++;
          end
          r++;
          mLastWrite = 1'b0;
        end
      end
    end
  endtask

  // Requesters hold their line while they still have work and drop it on the ack edge.
  task automatic applyStimulus(input int nW, input int nR, input bit b, input bit rew);
    int datos[$];
    int w = 0;
    int r = 0;
    int budget;
    for (int i = 0; i < nW; i++) begin
      if (datosFijos.size() > 0) datos.push_back(datosFijos.pop_front());
      else datos.push_back(int'($urandom_range(0, 4095)));
    end
    predict(nW, nR, b, rew, datos);
    budget = 8 * (nW + nR + 2) + 20;
    bus.borrar_req    = b;
    bus.escribir_req  = (nW > 0);
    bus.escribir_dato = (nW > 0) ? 12'(datos[0]) : 12'd0;
    bus.leer_req      = (nR > 0);
    bus.rebobinar     = rew;
    while ((bus.borrar_req || bus.escribir_req || bus.leer_req) && budget > 0) begin
      @(posedge clock);
      #1;
      bus.rebobinar = 1'b0;
      budget--;
      if (bus.borrar_ack) bus.borrar_req = 1'b0;
      if (bus.escribir_ack || bus.escribir_error) begin
        w++;
        if (w >= nW) bus.escribir_req = 1'b0;
        else bus.escribir_dato = 12'(datos[w]);
      end
      if (bus.leer_ack) begin
        r++;
        if (r >= nR) bus.leer_req = 1'b0;
      end
    end
    checkOutput("handshake_timeout", 64'({bus.borrar_req, bus.escribir_req, bus.leer_req}), 64'd0);
    bus.borrar_req   = 1'b0;
    bus.escribir_req = 1'b0;
    bus.leer_req     = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    checkOutput("num_puntos", 64'(bus.num_puntos), 64'(mWr));
    checkOutput("lleno", 64'(bus.lleno), 64'(mWr == CAPACIDAD));
    checkOutput("vacio", 64'(bus.vacio), 64'(mWr == 0));
  endtask

  // Monitor: every strobe pops the next prediction; memory-port strobes must track their acks.
  always @(negedge clock) begin
    if (!resetN) begin
      ackCiclos.delete();
    end else begin
      checkOutput("rw_with_write_ack", 64'(bus.mem_leer_escribir), 64'(bus.escribir_ack));
      checkOutput("mem_reset_with_borrar_ack", 64'(bus.mem_reset), 64'(bus.borrar_ack));
      if (bus.borrar_ack || bus.escribir_ack || bus.escribir_error || bus.leer_ack) begin
        if (bus.borrar_ack) obs = EV_BORRAR;
        else if (bus.escribir_ack) obs = EV_WRITE;
        else if (bus.escribir_error) obs = EV_ERROR;
        else if (bus.leer_fin) obs = EV_FIN;
        else obs = EV_READ;
        if (obs == EV_READ) ackCiclos.push_back(ciclo);
        if (expEventos.size() == 0) begin
          checkOutput("unexpected_event", 64'(obs), 64'hFFFF);
        end else begin
          esperado = expEventos.pop_front();
          checkOutput("event_kind", 64'(obs), 64'(esperado.kind));
          if (esperado.kind == EV_WRITE) begin
            checkOutput("write_addr", 64'(bus.mem_direccion), 64'(esperado.addr));
            checkOutput("write_data", 64'(bus.mem_dato_escribir), 64'(esperado.data));
          end else if (esperado.kind == EV_READ) begin
            checkOutput("read_addr", 64'(bus.mem_direccion), 64'(esperado.addr));
          end else if (esperado.kind != EV_BORRAR) begin
            checkOutput("no_mem_access", 64'({bus.mem_leer_escribir, bus.mem_reset}), 64'd0);
          end
        end
      end
      if (bus.leer_valido) begin
        if (expDatos.size() == 0) checkOutput("unexpected_leer_valido", 64'(bus.leer_dato), 64'hFFFF);
        else checkOutput("leer_dato", 64'(bus.leer_dato), 64'(expDatos.pop_front()));
        if (ackCiclos.size() == 0) checkOutput("read_latency_noack", 64'd1, 64'd0);
        else checkOutput("read_latency", 64'(ciclo - ackCiclos.pop_front()), 64'd2);
      end
    end
  end

  initial begin
    int budget;
    int vacios[$];
    bus.escribir_req  = 1'b0;
    bus.escribir_dato = '0;
    bus.leer_req      = 1'b0;
    bus.rebobinar     = 1'b0;
    bus.borrar_req    = 1'b0;
    resetN = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_outputs", salidas(), 64'd0);
    checkOutput("reset_vacio", 64'(bus.vacio), 64'd1);
    #1 resetN = 1'b1;
    @(posedge clock);
    #1;

    $display("[TB] three fixed writes, then four reads");
    datosFijos = '{'h041, 'h082, 'h0C3};
    applyStimulus(3, 0, 1'b0, 1'b0);
    applyStimulus(0, 4, 1'b0, 1'b0);

    $display("[TB] write/read tie, then clear with both pending");
    applyStimulus(2, 2, 1'b0, 1'b0);
    applyStimulus(1, 1, 1'b1, 1'b0);

    $display("[TB] rewind after two of three reads");
    applyStimulus(3, 0, 1'b1, 1'b0);
    applyStimulus(0, 2, 1'b0, 1'b0);
    applyStimulus(0, 1, 1'b0, 1'b1);

    $display("[TB] random traffic");
    for (int it = 0; it < 40; it++) begin
      applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("[TB] fill to capacity plus one");
    applyStimulus(0, 0, 1'b1, 1'b0);
    applyStimulus(CAPACIDAD + 1, 0, 1'b0, 1'b0);
    applyStimulus(0, 2, 1'b0, 1'b0);

    $display("[TB] reset while waiting for read data");
    applyStimulus(3, 0, 1'b1, 1'b0);
    applyStimulus(0, 1, 1'b0, 1'b0);
    predict(0, 1, 1'b0, 1'b0, vacios);
    bus.leer_req = 1'b1;
    budget = 20;
    do begin
      @(posedge clock);
      #1;
      budget--;
    end while (!bus.leer_ack && budget > 0);
    bus.leer_req = 1'b0;
    checkOutput("abort_read_ack", 64'(bus.leer_ack), 64'd1);
    @(posedge clock);
    #1;
    resetN = 1'b0;
    #1;
    checkOutput("async_reset_outputs", salidas(), 64'd0);
    expDatos.delete();
    mWr = 0;
    mRd = 0;
    mLastWrite = 1'b0;
    repeat (2) @(posedge clock);
    #2 resetN = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("post_reset_vacio", 64'(bus.vacio), 64'd1);
    applyStimulus(2, 1, 1'b0, 1'b0);

    checkOutput("pending_events", 64'(expEventos.size()), 64'd0);
    checkOutput("pending_data", 64'(expDatos.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
